act_lut_writer: RTL

- Runtime-loadable activation lookup table (tanh/sigmoid style).
- Streams 2**inWidth words from the configuration path into on-chip memory using a valid/ready handshake.
- Serves neuron lookups from that memory once the full table is loaded.
- Write-side counterpart of the fixed activation ROMs; allows table replacement without resynthesis.

---
 rtl/act_pkg.sv | 17 +
 rtl/act_lut_ram.sv | 26 ++
 rtl/act_lut_writer.sv | 118 +++++++++++
 3 files changed

// File: rtl/act_pkg.sv
// Shared types and helpers for the runtime-loadable activation LUT.
package act_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } act_state_t;

    localparam int SUM_W = 32;

    // Signed lookup input to table index: invert the MSB (offset binary).
    function automatic logic [31:0] offset_addr(input logic [31:0] x, input int unsigned w);
        return x ^ (32'd1 << (w - 1));
    endfunction

endpackage

// File: rtl/act_lut_ram.sv
// Simple dual-port table memory: one write port, one read port with registered address.
module act_lut_ram #(
    parameter int inWidth   = 10,
    parameter int dataWidth = 16
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [inWidth-1:0]   wr_addr,
    input  logic [dataWidth-1:0] wr_data,
    input  logic [inWidth-1:0]   rd_addr,
    output logic [dataWidth-1:0] rd_data
);

    logic [dataWidth-1:0] mem [2**inWidth];
    logic [inWidth-1:0]   rd_addr_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_addr_q <= rd_addr;
    end

    assign rd_data = mem[rd_addr_q];

endmodule

// File: rtl/act_lut_writer.sv
// Activation LUT loaded over a valid/ready stream, served through a 2-cycle read pipeline.
// Optional LUT_CHECKSUM_EN adds lut_sum, a running sum of the uploaded words.
//
// state | meaning
// IDLE  | waiting for load_start; table served if lut_valid
// LOAD  | accepting 2**inWidth words, s_ready/busy high
// DONE  | one cycle: load_done pulse, table becomes valid on exit
module act_lut_writer
    import act_pkg::*;
#(
    parameter int inWidth   = 10,
    parameter int dataWidth = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load_start,
    input  logic [dataWidth-1:0]        s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic                        busy,
    output logic                        load_done,
    output logic                        lut_valid,
`ifdef LUT_CHECKSUM_EN
    output logic [SUM_W-1:0]            lut_sum,
`endif
    input  logic                        x_valid,
    input  logic signed [inWidth-1:0]   x,
    output logic                        out_valid,
    output logic signed [dataWidth-1:0] out
);

    localparam logic [inWidth:0] LAST_ADDR = (inWidth+1)'(2**inWidth - 1);

    act_state_t           state;
    logic [inWidth:0]     wr_addr;
    logic                 wr_en;
    logic [inWidth-1:0]   rd_addr;
    logic [dataWidth-1:0] rd_data;
    logic                 x_valid_q;

    assign wr_en   = (state == LOAD) && s_valid && s_ready;
    assign rd_addr = inWidth'(offset_addr(32'(x), inWidth));

    act_lut_ram #(
        .inWidth   (inWidth),
        .dataWidth (dataWidth)
    ) u_ram (
        .clk     (clk),
        .we      (wr_en),
        .wr_addr (wr_addr[inWidth-1:0]),
        .wr_data (s_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_addr   <= '0;
            s_ready   <= 1'b0;
            busy      <= 1'b0;
            load_done <= 1'b0;
            lut_valid <= 1'b0;
`ifdef LUT_CHECKSUM_EN
            lut_sum   <= '0;
`endif
        end else begin
            load_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state     <= LOAD;
                        lut_valid <= 1'b0;
                        wr_addr   <= '0;
                        s_ready   <= 1'b1;
                        busy      <= 1'b1;
`ifdef LUT_CHECKSUM_EN
                        lut_sum   <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (s_valid && s_ready) begin
                        wr_addr <= wr_addr + 1'b1;
`ifdef LUT_CHECKSUM_EN
                        lut_sum <= lut_sum + SUM_W'(s_data);
`endif
                        if (wr_addr == LAST_ADDR) begin
                            state     <= DONE;
                            s_ready   <= 1'b0;
                            load_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    lut_valid <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // An incomplete table is never exposed: results read as 0 until lut_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_valid_q <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
        end else begin
            x_valid_q <= x_valid;
            out_valid <= x_valid_q;
            out       <= lut_valid ? $signed(rd_data) : '0;
        end
    end

endmodule
